aes_decrypt_core: RTL and testbench

Iterative AES-128 inverse cipher: the decryption counterpart of the pipelined encryption block. Accepts one 128-bit ciphertext plus the final (round-10) round key over a valid/ready handshake. Runs ten inverse rounds, one per clock, and derives each earlier round key on the fly by running the key schedule backwards. Returns the plaintext and the recovered cipher key (round-0 key) over a second valid/ready handshake. It sits on the receive side of the link, opposite the encryption pipeline.

---
 rtl/aes_dec_pkg.sv | 74 +++++++
 rtl/aes_decrypt_core_if.sv | 22 ++
 rtl/aes_inv_sbox.sv | 9 +
 rtl/aes_sbox.sv | 12 +
 rtl/aes_decrypt_core.sv | 105 ++++++++++
 tb/tb_aes_decrypt_core.sv | 272 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/aes_dec_pkg.sv
// aes_dec_pkg: FSM encoding, round constants and GF(2^8) helpers for the AES-128 inverse cipher.
package aes_dec_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam logic [7:0] RCON_LAST      = 8'h36;
    localparam logic [7:0] INV_XTIME_POLY = 8'h8D;
    localparam int         NR             = 10;

    function automatic logic [7:0] gf_mul2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul4(input logic [7:0] a);
        return gf_mul2(gf_mul2(a));
    endfunction

    function automatic logic [7:0] inv_xtime(input logic [7:0] x);
        return x[0] ? ({1'b0, x[7:1]} ^ INV_XTIME_POLY) : {1'b0, x[7:1]};
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = gf_mul2(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
        logic [7:0] a, m2, m4, m8;
        logic [7:0] e [4];
        logic [7:0] b [4];
        logic [7:0] d [4];
        logic [7:0] n [4];
        logic [31:0] r;
        logic [1:0] j;
        for (int i = 0; i < 4; i++) begin
            a    = c[31-8*i -: 8];
            m2   = gf_mul2(a);
            m4   = gf_mul4(a);
            m8   = gf_mul2(m4);
            e[i] = m8 ^ m4 ^ m2;
            b[i] = m8 ^ m2 ^ a;
            d[i] = m8 ^ m4 ^ a;
            n[i] = m8 ^ a;
        end
        r = '0;
        for (int i = 0; i < 4; i++) begin
            j = 2'(i);
            r[31-8*i -: 8] = e[j] ^ b[j + 2'd1] ^ d[j + 2'd2] ^ n[j + 2'd3];
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_decrypt_core_if.sv
// aes_decrypt_core_if: ciphertext/key input channel and plaintext/key output channel.
interface aes_decrypt_core_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [127:0] out_key;
    logic         busy;

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data, out_key, busy
    );

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data, out_key, busy
    );
endinterface

// File: rtl/aes_inv_sbox.sv
// aes_inv_sbox: combinational AES inverse S-box (inverse affine map followed by GF(2^8) inversion).
module aes_inv_sbox
    import aes_dec_pkg::*;
(
    input  logic [7:0] x,
    output logic [7:0] y
);
    assign y = gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
endmodule

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box (GF(2^8) inversion followed by the affine map).
module aes_sbox
    import aes_dec_pkg::*;
(
    input  logic [7:0] x,
    output logic [7:0] y
);
    logic [7:0] v;

    assign v = gf_inv(x);
    assign y = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
endmodule

// File: rtl/aes_decrypt_core.sv
// aes_decrypt_core: iterative AES-128 inverse cipher, one round per clock, round keys
// derived backwards from the round-10 key.
module aes_decrypt_core
    import aes_dec_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    aes_decrypt_core_if.slave bus
);
    state_t       fsm_q, fsm_d;
    logic [127:0] st_q, st_d, key_q, key_d;
    logic [127:0] out_data_q, out_data_d, out_key_q, out_key_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   round_q, round_d;
    logic         in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;

    logic [127:0] shifted, subbed, pre, mixed, prev_key, round_st;
    logic [31:0]  w3p, rot_w, sub_w;

    for (genvar i = 0; i < 16; i++) begin : g_byte
        localparam int SRC = 4 * (((i / 4) - (i % 4) + 4) % 4) + (i % 4);
        assign shifted[127-8*i -: 8] = st_q[127-8*SRC -: 8];
        aes_inv_sbox u_isb (.x(shifted[127-8*i -: 8]), .y(subbed[127-8*i -: 8]));
    end

    // Key schedule run backwards: w3..w1 unwind by XOR, w0 needs SubWord(RotWord(w3')).
    assign w3p   = key_q[31:0] ^ key_q[63:32];
    assign rot_w = {w3p[23:0], w3p[31:24]};

    for (genvar j = 0; j < 4; j++) begin : g_col
        aes_sbox u_sb (.x(rot_w[31-8*j -: 8]), .y(sub_w[31-8*j -: 8]));
        assign mixed[127-32*j -: 32] = inv_mix_column(pre[127-32*j -: 32]);
    end

    assign prev_key = {key_q[127:96] ^ sub_w ^ {rcon_q, 24'h0},
                       key_q[95:64] ^ key_q[127:96],
                       key_q[63:32] ^ key_q[95:64],
                       w3p};
    assign pre      = subbed ^ prev_key;
    assign round_st = (round_q == 4'd0) ? pre : mixed;

    always_comb begin
        fsm_d      = fsm_q;
        st_d       = st_q;
        key_d      = key_q;
        rcon_d     = rcon_q;
        round_d    = round_q;
        out_data_d = out_data_q;
        out_key_d  = out_key_q;
        if (fsm_q == IDLE && bus.in_valid) begin
            fsm_d   = ROUND;
            st_d    = bus.in_data ^ bus.in_key;
            key_d   = bus.in_key;
            rcon_d  = RCON_LAST;
            round_d = 4'(NR - 1);
        end
        if (fsm_q == ROUND) begin
            st_d    = round_st;
            key_d   = prev_key;
            rcon_d  = inv_xtime(rcon_q);
            round_d = (round_q == 4'd0) ? 4'd0 : round_q - 4'd1;
            if (round_q == 4'd0) begin
                fsm_d      = DONE;
                out_data_d = round_st;
                out_key_d  = prev_key;
            end
        end
        if (fsm_q == DONE && bus.out_ready) fsm_d = IDLE;
        in_ready_d  = fsm_d == IDLE;
        busy_d      = fsm_d == ROUND;
        out_valid_d = fsm_d == DONE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q       <= IDLE;
            st_q        <= '0;
            key_q       <= '0;
            rcon_q      <= '0;
            round_q     <= '0;
            out_data_q  <= '0;
            out_key_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            st_q        <= st_d;
            key_q       <= key_d;
            rcon_q      <= rcon_d;
            round_q     <= round_d;
            out_data_q  <= out_data_d;
            out_key_q   <= out_key_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_key   = out_key_q;
endmodule

// File: tb/tb_aes_decrypt_core.sv
// tb_aes_decrypt_core: directed FIPS-197 vectors plus random blocks against a forward-cipher model.
module tb_aes_decrypt_core;

    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic clock;
    logic reset_n;
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    logic [7:0] sb [256];

    aes_decrypt_core_if bus ();

    aes_decrypt_core dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    // S-box built by walking the multiplicative group with generator 3 and its inverse.
    task automatic init_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    task automatic aes_enc(input logic [127:0] pt, input logic [127:0] k,
                           output logic [127:0] ct, output logic [127:0] k10);
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc, a0, a1, a2, a3;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int b = 0; b < 16; b++) t[b] = sb[s[b]];
            for (int b = 0; b < 16; b++) s[b] = t[4*(((b/4) + (b%4)) % 4) + (b%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c];
                    a1 = s[4*c+1];
                    a2 = s[4*c+2];
                    a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*r + b/4][31-8*(b%4) -: 8];
        end
        for (int b = 0; b < 16; b++) ct[127-8*b -: 8] = s[b];
        k10 = {w[40], w[41], w[42], w[43]};
    endtask

    task automatic send(input logic [127:0] d, input logic [127:0] k, output int at);
        logic acc;
        int   n;
        bus.in_data  = d;
        bus.in_key   = k;
        bus.in_valid = 1'b1;
        n = 0;
        do begin
            acc = bus.in_ready;
            @(posedge clock);
            #1;
            n++;
        end while (!acc && n < 100);
        bus.in_valid = 1'b0;
        bus.in_data  = ~d;
        bus.in_key   = ~k;
        at = cyc;
        checks++;
        if (!acc) begin
            fails++;
            $display("FAIL accept: in_ready not seen within %0d cycles", n);
        end
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #2;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.out_data !== 128'h0) begin fails++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
        checks++; if (bus.out_key !== 128'h0) begin fails++; $display("FAIL reset_out_key: got %h want 0", bus.out_key); end
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_fips_c1();
        int at, n;
        send(C1_CT, C1_K10, at);
        checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL c1_busy: got %b want 1", bus.busy); end
        checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL c1_in_ready_low: got %b want 0", bus.in_ready); end
        wait_out(n);
        checks++; if (n !== 10) begin fails++; $display("FAIL c1_latency: got %0d want 10", n); end
        checks++; if (bus.out_data !== C1_PT) begin fails++; $display("FAIL c1_data: got %h want %h", bus.out_data, C1_PT); end
        checks++; if (bus.out_key !== C1_KEY) begin fails++; $display("FAIL c1_key: got %h want %h", bus.out_key, C1_KEY); end
        take();
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL c1_in_ready_back: got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL c1_out_valid_drop: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        int at, n;
        send(C1_CT, C1_K10, at);
        wait_out(n);
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.out_valid); end
            checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
            checks++; if (bus.out_data !== C1_PT) begin fails++; $display("FAIL bp_data[%0d]: got %h want %h", i, bus.out_data, C1_PT); end
            checks++; if (bus.out_key !== C1_KEY) begin fails++; $display("FAIL bp_key[%0d]: got %h want %h", i, bus.out_key, C1_KEY); end
        end
        take();
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_busy_reject();
        int at, n;
        send(C1_CT, C1_K10, at);
        bus.in_data = B_CT;
        bus.in_key  = B_K10;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = ~bus.in_valid;
            @(posedge clock);
            #1;
            checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reject_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        wait_out(n);
        checks++; if (n + 6 !== 10) begin fails++; $display("FAIL reject_latency: got %0d want 10", n + 6); end
        checks++; if (bus.out_data !== C1_PT) begin fails++; $display("FAIL reject_data: got %h want %h", bus.out_data, C1_PT); end
        checks++; if (bus.out_key !== C1_KEY) begin fails++; $display("FAIL reject_key: got %h want %h", bus.out_key, C1_KEY); end
        take();
        send(B_CT, B_K10, at);
        wait_out(n);
        checks++; if (n !== 10) begin fails++; $display("FAIL appb_latency: got %0d want 10", n); end
        checks++; if (bus.out_data !== B_PT) begin fails++; $display("FAIL appb_data: got %h want %h", bus.out_data, B_PT); end
        checks++; if (bus.out_key !== B_KEY) begin fails++; $display("FAIL appb_key: got %h want %h", bus.out_key, B_KEY); end
        take();
    endtask

    task automatic test_reset_mid();
        int at, n;
        send(C1_CT, C1_K10, at);
        repeat (5) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.out_data !== 128'h0) begin fails++; $display("FAIL midrst_data: got %h want 0", bus.out_data); end
        checks++; if (bus.out_key !== 128'h0) begin fails++; $display("FAIL midrst_key: got %h want 0", bus.out_key); end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        send(C1_CT, C1_K10, at);
        wait_out(n);
        checks++; if (n !== 10) begin fails++; $display("FAIL midrst_latency: got %0d want 10", n); end
        checks++; if (bus.out_data !== C1_PT) begin fails++; $display("FAIL midrst_after_data: got %h want %h", bus.out_data, C1_PT); end
        checks++; if (bus.out_key !== C1_KEY) begin fails++; $display("FAIL midrst_after_key: got %h want %h", bus.out_key, C1_KEY); end
        take();
    endtask

    task automatic test_back_to_back();
        logic [127:0] pt, key, ct, k10;
        int at, prev, n;
        prev = 0;
        bus.out_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            aes_enc(pt, key, ct, k10);
            send(ct, k10, at);
            if (v > 0) begin
                checks++; if (at - prev !== 12) begin fails++; $display("FAIL b2b_spacing[%0d]: got %0d want 12", v, at - prev); end
            end
            prev = at;
            wait_out(n);
            checks++; if (n !== 10) begin fails++; $display("FAIL b2b_latency[%0d]: got %0d want 10", v, n); end
            checks++; if (bus.out_data !== pt) begin fails++; $display("FAIL b2b_data[%0d]: got %h want %h", v, bus.out_data, pt); end
            checks++; if (bus.out_key !== key) begin fails++; $display("FAIL b2b_key[%0d]: got %h want %h", v, bus.out_key, key); end
        end
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_key    = '0;
        bus.out_ready = 1'b0;
        reset_n       = 1'b1;
        init_sbox();
        test_reset();
        test_fips_c1();
        test_backpressure();
        test_busy_reject();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
